// File: rtl/dram_channel_model_pkg.sv
// Shared types and address-decode helpers for the multi-channel DRAM timing/storage model.
package dram_channel_model_pkg;

  localparam int max_addr_width_lp = 32;

  typedef struct packed {
    logic                         write_not_read;
    logic [max_addr_width_lp-1:0] ch_addr;
  } dram_req_s;

  typedef enum logic {
    e_idle = 1'b0,
    e_busy = 1'b1
  } engine_state_e;

  function automatic logic [max_addr_width_lp-1:0] word_of(
    input logic [max_addr_width_lp-1:0] addr,
    input int                           byte_shift
  );
    return addr >> byte_shift;
  endfunction

  function automatic logic [max_addr_width_lp-1:0] row_of(
    input logic [max_addr_width_lp-1:0] word,
    input int                           num_columns
  );
    return word / num_columns;
  endfunction

endpackage

// File: rtl/dram_channel_model_ch.sv
// One DRAM channel: request queue, service engine, open-row register and word storage.
// Define DRAM_CHANNEL_TRACE_EN to print a line for every completion.
module dram_channel_model_ch
  import dram_channel_model_pkg::*;
#(
  parameter int channel_addr_width_p = 12,
  parameter int data_width_p         = 32,
  parameter int num_columns_p        = 16,
  parameter int fifo_els_p           = 4,
  parameter int row_hit_latency_p    = 4,
  parameter int row_miss_latency_p   = 10
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            v_i,
  input  logic                            write_not_read_i,
  input  logic [channel_addr_width_p-1:0] ch_addr_i,
  output logic                            yumi_o,
  input  logic                            data_v_i,
  input  logic [data_width_p-1:0]         data_i,
  output logic                            data_yumi_o,
  output logic                            data_v_o,
  output logic [data_width_p-1:0]         data_o,
  output logic                            write_done_o,
  output logic [channel_addr_width_p-1:0] write_done_ch_addr_o
);

  localparam int byte_shift_lp = $clog2(data_width_p / 8);
  localparam int word_w_lp     = channel_addr_width_p - byte_shift_lp;
  localparam int mem_els_lp    = 1 << word_w_lp;
  localparam int ptr_w_lp      = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp      = $clog2(fifo_els_p + 1);
  localparam int max_lat_lp    = (row_miss_latency_p > row_hit_latency_p) ? row_miss_latency_p
                                                                          : row_hit_latency_p;
  localparam int lat_w_lp      = $clog2(max_lat_lp + 1);

  dram_req_s                       q_mem [fifo_els_p];
  logic [ptr_w_lp-1:0]             rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0]             q_count;
  logic                            q_full, q_empty, push, pop, start, done;
  dram_req_s                       in_req, head, cur_req;
  engine_state_e                   state, state_n;
  logic [lat_w_lp-1:0]             count;
  logic [max_addr_width_lp-1:0]    open_row, head_row;
  logic                            open_row_v, head_hit;
  logic [word_w_lp-1:0]            cur_word;
  logic [data_width_p-1:0]         mem [mem_els_lp] = '{default: '0};

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_full   = (q_count == cnt_w_lp'(fifo_els_p));
  assign q_empty  = (q_count == '0);
  assign yumi_o   = v_i & ~q_full & reset_n_i;
  assign in_req   = '{write_not_read: write_not_read_i, ch_addr: max_addr_width_lp'(ch_addr_i)};

  // An empty queue flows the incoming request straight to an idle engine.
  assign head     = q_empty ? in_req : q_mem[rd_ptr];
  assign start    = (state == e_idle) & (~q_empty | yumi_o);
  assign pop      = (state == e_idle) & ~q_empty;
  assign push     = yumi_o & ~((state == e_idle) & q_empty);
  assign head_row = row_of(word_of(head.ch_addr, byte_shift_lp), num_columns_p);
  assign head_hit = open_row_v & (open_row == head_row);
  assign done     = (state == e_busy) & (count == lat_w_lp'(1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      q_count <= q_count + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) q_mem[wr_ptr] <= in_req;
  end

  always_comb begin
    state_n = state;
    case (state)
      e_idle:  if (start) state_n = e_busy;
      e_busy:  if (done)  state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= e_idle;
      count      <= '0;
      cur_req    <= '0;
      open_row   <= '0;
      open_row_v <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        count      <= head_hit ? lat_w_lp'(row_hit_latency_p) : lat_w_lp'(row_miss_latency_p);
        cur_req    <= head;
        open_row   <= head_row;
        open_row_v <= 1'b1;
      end else if (state == e_busy) begin
        count <= count - 1'b1;
      end
    end
  end

  assign cur_word             = word_w_lp'(word_of(cur_req.ch_addr, byte_shift_lp));
  assign data_v_o             = done & ~cur_req.write_not_read;
  assign data_o               = data_v_o ? mem[cur_word] : '0;
  assign write_done_o         = done & cur_req.write_not_read;
  assign write_done_ch_addr_o = write_done_o ? channel_addr_width_p'(cur_req.ch_addr) : '0;
  assign data_yumi_o          = write_done_o & data_v_i;

  always_ff @(posedge clk_i) begin
    if (data_yumi_o) mem[cur_word] <= data_i;
  end

`ifdef DRAM_CHANNEL_TRACE_EN
  logic hit_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  hit_r <= 1'b0;
    else if (start)  hit_r <= head_hit;
  end

  always_ff @(posedge clk_i) begin
    if (done)
      $display("%0t %m %s addr=0x%0h data=0x%0h %s", $time,
               cur_req.write_not_read ? "W" : "R",
               channel_addr_width_p'(cur_req.ch_addr),
               cur_req.write_not_read ? (data_v_i ? data_i : '0) : mem[cur_word],
               hit_r ? "hit" : "miss");
  end
`endif

endmodule

// File: rtl/dram_channel_model.sv
// Multi-channel DRAM timing/storage model; each channel is an independent dram_channel_model_ch.
// Define DRAM_CHANNEL_TRACE_EN to print a line for every completion.
module dram_channel_model
  import dram_channel_model_pkg::*;
#(
  parameter int num_channels_p       = 2,
  parameter int channel_addr_width_p = 12,
  parameter int data_width_p         = 32,
  parameter int num_columns_p        = 16,
  parameter int fifo_els_p           = 4,
  parameter int row_hit_latency_p    = 4,
  parameter int row_miss_latency_p   = 10
) (
  input  logic                                                 clk_i,
  input  logic                                                 reset_n_i,
  input  logic [num_channels_p-1:0]                            v_i,
  input  logic [num_channels_p-1:0]                            write_not_read_i,
  input  logic [num_channels_p-1:0][channel_addr_width_p-1:0] ch_addr_i,
  output logic [num_channels_p-1:0]                            yumi_o,
  input  logic [num_channels_p-1:0]                            data_v_i,
  input  logic [num_channels_p-1:0][data_width_p-1:0]         data_i,
  output logic [num_channels_p-1:0]                            data_yumi_o,
  output logic [num_channels_p-1:0]                            data_v_o,
  output logic [num_channels_p-1:0][data_width_p-1:0]         data_o,
  output logic [num_channels_p-1:0]                            write_done_o,
  output logic [num_channels_p-1:0][channel_addr_width_p-1:0] write_done_ch_addr_o
);

  for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
    dram_channel_model_ch #(
      .channel_addr_width_p(channel_addr_width_p),
      .data_width_p        (data_width_p),
      .num_columns_p       (num_columns_p),
      .fifo_els_p          (fifo_els_p),
      .row_hit_latency_p   (row_hit_latency_p),
      .row_miss_latency_p  (row_miss_latency_p)
    ) u_ch (
      .clk_i               (clk_i),
      .reset_n_i           (reset_n_i),
      .v_i                 (v_i[c]),
      .write_not_read_i    (write_not_read_i[c]),
      .ch_addr_i           (ch_addr_i[c]),
      .yumi_o              (yumi_o[c]),
      .data_v_i            (data_v_i[c]),
      .data_i              (data_i[c]),
      .data_yumi_o         (data_yumi_o[c]),
      .data_v_o            (data_v_o[c]),
      .data_o              (data_o[c]),
      .write_done_o        (write_done_o[c]),
      .write_done_ch_addr_o(write_done_ch_addr_o[c])
    );
  end

endmodule

// File: tb/tb_dram_channel_model.sv
// Directed self-checking bench for dram_channel_model: latency, storage, backpressure and reset.
module tb_dram_channel_model;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [1:0]        v_i, write_not_read_i, yumi_o, data_v_i, data_yumi_o, data_v_o, write_done_o;
  logic [1:0][11:0]  ch_addr_i, write_done_ch_addr_o;
  logic [1:0][31:0]  data_i, data_o;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  dram_channel_model dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .v_i                 (v_i),
    .write_not_read_i    (write_not_read_i),
    .ch_addr_i           (ch_addr_i),
    .yumi_o              (yumi_o),
    .data_v_i            (data_v_i),
    .data_i              (data_i),
    .data_yumi_o         (data_yumi_o),
    .data_v_o            (data_v_o),
    .data_o              (data_o),
    .write_done_o        (write_done_o),
    .write_done_ch_addr_o(write_done_ch_addr_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one request and hold it until accepted; returns the acceptance cycle.
  task automatic applyStimulus(input int ch, input logic wnr, input logic [11:0] addr,
                               input string tag, output int acc);
    logic ok = 1'b0;
    acc = -1;
    @(posedge clk_i); #1;
    v_i[ch] = 1'b1;
    write_not_read_i[ch] = wnr;
    ch_addr_i[ch] = addr;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (yumi_o[ch]) begin
        acc = cyc;
        ok  = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_accept"}, 64'(ok), 64'd1);
    @(posedge clk_i); #1;
    v_i[ch] = 1'b0;
  endtask

  task automatic runAccess(input int ch, input logic wnr, input logic [11:0] addr, input int exp_lat,
                           input logic [31:0] exp_data, input logic exp_dyumi, input string tag);
    int   k, d = -1;
    logic seen = 1'b0, early_dyumi = 1'b0;
    logic rv = 1'b0, wd = 1'b0, dy = 1'b0;
    logic [31:0] dat = '0;
    logic [11:0] wa = '0;
    applyStimulus(ch, wnr, addr, tag, k);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (data_v_o[ch] || write_done_o[ch]) begin
        d = cyc; rv = data_v_o[ch]; wd = write_done_o[ch];
        dat = data_o[ch]; wa = write_done_ch_addr_o[ch]; dy = data_yumi_o[ch];
        seen = 1'b1;
        break;
      end
      if (data_yumi_o[ch]) early_dyumi = 1'b1;
    end
    checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
    checkOutput({tag, "_lat"}, 64'(d - k), 64'(exp_lat));
    checkOutput({tag, "_early_dyumi"}, 64'(early_dyumi), 64'd0);
    if (wnr) begin
      checkOutput({tag, "_wdone"}, {rv, wd}, 64'b01);
      checkOutput({tag, "_waddr"}, 64'(wa), 64'(addr));
      checkOutput({tag, "_dyumi"}, 64'(dy), 64'(exp_dyumi));
    end else begin
      checkOutput({tag, "_rvalid"}, {rv, wd}, 64'b10);
      checkOutput({tag, "_rdata"}, 64'(dat), 64'(exp_data));
    end
    @(negedge clk_i);
    checkOutput({tag, "_pulse"}, {data_v_o[ch], write_done_o[ch], data_yumi_o[ch]}, 64'd0);
  endtask

  initial begin
    int k, d0, d1, n_rd, second;
    logic [31:0] r0, r1;

    reset_n_i = 1'b0;
    v_i = 2'b11;
    write_not_read_i = '0;
    ch_addr_i = '0;
    data_v_i = '0;
    data_i = '0;

    @(negedge clk_i);
    checkOutput("reset_yumi", 64'(yumi_o), 64'd0);
    checkOutput("reset_outs", {data_v_o, write_done_o, data_yumi_o}, 64'd0);
    checkOutput("reset_data", {data_o, write_done_ch_addr_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    v_i = '0;

    $display("[TB] basic read/write/hit");
    runAccess(0, 1'b0, 12'h000, 10, 32'h0, 1'b0, "rd_init");
    data_v_i[0] = 1'b1;
    data_i[0] = 32'hDEADBEEF;
    runAccess(0, 1'b1, 12'h040, 10, 32'h0, 1'b1, "wr_040");
    data_v_i[0] = 1'b0;
    data_i[0] = '0;
    runAccess(0, 1'b0, 12'h040, 4, 32'hDEADBEEF, 1'b0, "rd_040_hit");
    runAccess(0, 1'b0, 12'h044, 4, 32'h0, 1'b0, "rd_044_hit");

    $display("[TB] back-to-back backpressure");
    @(posedge clk_i); #1;
    v_i[0] = 1'b1;
    write_not_read_i[0] = 1'b0;
    ch_addr_i[0] = 12'h000;
    n_rd = 0;
    second = -1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk_i);
      if (i <= 12)
        checkOutput($sformatf("b2b_yumi_c%0d", i), 64'(yumi_o[0]), 64'((i < 5) || (i == 12)));
      if (data_v_o[0]) begin
        n_rd++;
        if (n_rd == 2) second = i;
      end
      if (i == 12) begin
        @(posedge clk_i); #1;
        v_i[0] = 1'b0;
      end
    end
    checkOutput("b2b_reads", 64'(n_rd), 64'd6);
    checkOutput("b2b_second_done", 64'(second), 64'd15);

    $display("[TB] reset during busy read");
    applyStimulus(0, 1'b0, 12'h000, "rst_rd", k);
    repeat (3) @(posedge clk_i);
    #1;
    reset_n_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_mid_outs", {data_v_o, write_done_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    n_rd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (data_v_o[0]) n_rd++;
    end
    checkOutput("rst_dropped", 64'(n_rd), 64'd0);
    runAccess(0, 1'b0, 12'h000, 10, 32'h0, 1'b0, "rd_after_rst");

    $display("[TB] simultaneous channels");
    @(posedge clk_i); #1;
    v_i = 2'b11;
    write_not_read_i = 2'b00;
    ch_addr_i[0] = 12'h100;
    ch_addr_i[1] = 12'h100;
    @(negedge clk_i);
    k = cyc;
    checkOutput("dual_yumi", 64'(yumi_o), 64'b11);
    @(posedge clk_i); #1;
    v_i = 2'b00;
    d0 = -1; d1 = -1; r0 = 32'hFFFFFFFF; r1 = 32'hFFFFFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (data_v_o[0] && d0 < 0) begin d0 = cyc; r0 = data_o[0]; end
      if (data_v_o[1] && d1 < 0) begin d1 = cyc; r1 = data_o[1]; end
    end
    checkOutput("dual_lat_ch0", 64'(d0 - k), 64'd10);
    checkOutput("dual_lat_ch1", 64'(d1 - k), 64'd10);
    checkOutput("dual_data", {r0, r1}, 64'd0);

    $display("[TB] write without data");
    data_v_i[0] = 1'b0;
    data_i[0] = 32'h12345678;
    runAccess(0, 1'b1, 12'h080, 10, 32'h0, 1'b0, "wr_080_nodata");
    data_i[0] = '0;
    runAccess(0, 1'b0, 12'h080, 4, 32'h0, 1'b0, "rd_080");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
